uart_reg_bridge: RTL and testbench
==================================

Name: uart_reg_bridge

Overview:
Command-frame bridge between the UART duplex block's FIFO interfaces and an 8-bit register bus. Drains received bytes from the UART receive FIFO and parses fixed 5-byte command frames. Performs one register write or read per frame, then pushes an acknowledge or response frame into the UART send FIFO. Sits directly downstream of the UART receive path and upstream of its transmit path.

Parameters:
ADDR_WIDTH, 8, width of both UART FIFO fill-level inputs; must match the UART's ADDR_WIDTH.
TIMEOUT_CLKS, 50000, inter-byte timeout in CLK cycles for a partially received frame (1 ms at 50 MHz).

Ports:
CLK  in  1  system clock; all logic on posedge.
RST  in  1  synchronous active-high reset.
RX_RDREQ  out  1  read strobe to the UART receive FIFO.
RX_DOUT  in  8  receive FIFO data, valid the cycle after RX_RDREQ.
RX_USEDW  in  ADDR_WIDTH  receive FIFO fill level.
TX_WRREQ  out  1  write strobe to the UART send FIFO.
TX_DIN  out  8  byte written when TX_WRREQ=1.
TX_USEDW  in  ADDR_WIDTH  send FIFO fill level.
REG_ADDR  out  8  register address.
REG_WDATA  out  8  register write data.
REG_WE  out  1  one-cycle write strobe.
REG_RE  out  1  one-cycle read strobe.
REG_RDATA  in  8  read data, valid the cycle after REG_RE.
ERR_CNT  out  8  count of bad frames, saturating at 255.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. RST=1 at a posedge zeroes all outputs and ERR_CNT and returns the FSM to HUNT. Any partial frame or pending response is dropped; no strobe fires on the cycle after RST. Receive FIFO contents are not affected.
- Frame format: 0x55 (SYNC), CMD, ADDR, DATA, CHK, where CHK = CMD^ADDR^DATA. CMD 0x01 = write, CMD 0x02 = read; DATA is ignored for reads but is still checksummed.
- Byte fetch: RX_RDREQ is a one-cycle pulse, issued only when RX_USEDW != 0 and no fetch is outstanding. The byte is captured from RX_DOUT on the next cycle, so the maximum rate is one byte per 2 cycles.
- FSM states: HUNT, COLLECT, EXEC, RD_WAIT, RESP_WAIT, RESP.
  - HUNT: fetched bytes other than 0x55 are discarded silently. On 0x55, go to COLLECT with the byte index set to 1.
  - COLLECT: capture CMD, ADDR, DATA, CHK in order. After CHK, go to EXEC.
  - EXEC, valid write: REG_ADDR=ADDR, REG_WDATA=DATA, REG_WE=1 for one cycle. Response is {0xAA}.
  - EXEC, valid read: REG_ADDR=ADDR, REG_RE=1 for one cycle, then RD_WAIT. RD_WAIT latches REG_RDATA on the next cycle. Response is {0xAA, RDATA, RDATA^0xAA}.
  - EXEC, checksum mismatch or unknown CMD: no register strobe, ERR_CNT increments, response is {0xEE}.
  - RESP_WAIT: stall until TX_USEDW < 2**ADDR_WIDTH-4, so the whole response fits. No partial responses are ever sent.
  - RESP: TX_WRREQ=1 on consecutive cycles, one response byte per cycle, in order. Then return to HUNT.
- Timeout: while in COLLECT, a 32-bit counter counts cycles since the last captured byte. On reaching TIMEOUT_CLKS: frame discarded, ERR_CNT increments, no response sent, FSM returns to HUNT. The counter clears on every capture.
- No receive-FIFO reads occur in EXEC, RD_WAIT, RESP_WAIT or RESP. Received bytes back-pressure in the FIFO.
- REG_ADDR and REG_WDATA hold their last values between strobes. REG_WE and REG_RE are never high together.
- ERR_CNT holds at 255 once saturated.

Decomposition:
- Package uart_bridge_pkg holds:
  - constants SYNC_BYTE=0x55, CMD_WR=0x01, CMD_RD=0x02, ACK_BYTE=0xAA, NAK_BYTE=0xEE, RESP_MAX=3;
  - the FSM state enum.
- One sub-module, uart_resp_seq: loads up to 3 bytes and a length, waits for FIFO room, then emits the TX_WRREQ/TX_DIN burst and signals done.

Test Plan:
- Write frame 55 01 10 3C 2D: exactly one REG_WE with ADDR=0x10, WDATA=0x3C; send FIFO receives AA; ERR_CNT=0.
- Read frame 55 02 20 00 22 with REG_RDATA=0x5A: one REG_RE with ADDR=0x20; send FIFO receives AA 5A F0 on 3 consecutive cycles.
- Bad checksum 55 01 10 3C 00: no REG_WE; send FIFO receives EE; ERR_CNT=1.
- Junk bytes 00 FF 55 01 01 01 01: junk ignored; one REG_WE with ADDR=0x01, WDATA=0x01; response AA.
- Send 55 01 then idle TIMEOUT_CLKS cycles: ERR_CNT=1, no strobes, no response; a following valid write frame executes normally.
- Hold TX_USEDW=2**ADDR_WIDTH-2 during a read: no TX_WRREQ until TX_USEDW drops below the limit, then the full 3-byte response is written. Assert RST mid-COLLECT: all outputs 0 next cycle, and a fresh frame decodes normally.

Source files
------------

// File: rtl/uart_bridge_pkg.sv
// Shared constants, state encodings and frame classification for the UART
// command-frame to register-bus bridge.
package uart_bridge_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'h55;
    localparam logic [7:0] CMD_WR    = 8'h01;
    localparam logic [7:0] CMD_RD    = 8'h02;
    localparam logic [7:0] ACK_BYTE  = 8'hAA;
    localparam logic [7:0] NAK_BYTE  = 8'hEE;
    localparam int         RESP_MAX  = 3;

    typedef enum logic [2:0] {
        HUNT,
        COLLECT,
        EXEC,
        RD_WAIT,
        RESP_WAIT,
        RESP
    } bridge_state_t;

    typedef enum logic [1:0] {
        FRAME_WR,
        FRAME_RD,
        FRAME_BAD
    } frame_kind_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_WAIT,
        SEQ_SEND
    } seq_state_t;

    // A frame is only actionable when the checksum matches and the command is known.
    function automatic frame_kind_t classify_frame(
        input logic [7:0] cmd,
        input logic [7:0] addr,
        input logic [7:0] data,
        input logic [7:0] chk
    );
        if ((cmd ^ addr ^ data) != chk) begin
            return FRAME_BAD;
        end
        if (cmd == CMD_WR) begin
            return FRAME_WR;
        end
        if (cmd == CMD_RD) begin
            return FRAME_RD;
        end
        return FRAME_BAD;
    endfunction

endpackage

// File: rtl/uart_resp_seq.sv
// Response sequencer: holds up to RESP_MAX bytes, waits until the send FIFO
// can take the largest response, then writes the bytes on consecutive cycles.
module uart_resp_seq
    import uart_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic [1:0]            len,
    input  logic [7:0]            byte0,
    input  logic [7:0]            byte1,
    input  logic [7:0]            byte2,
    input  logic [ADDR_WIDTH-1:0] TX_USEDW,
    output logic                  start,
    output logic                  done,
    output logic                  TX_WRREQ,
    output logic [7:0]            TX_DIN
);

    // Room for a full worst-case response keeps responses from ever being split.
    localparam logic [ADDR_WIDTH-1:0] TX_LIMIT = ADDR_WIDTH'((1 << ADDR_WIDTH) - 4);

    seq_state_t                 state;
    seq_state_t                 state_nxt;
    logic [RESP_MAX-1:0][7:0]   resp_buf;
    logic [1:0]                 len_q;
    logic [1:0]                 idx;
    logic                       room;
    logic                       last;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= SEQ_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            resp_buf <= '0;
            len_q    <= '0;
            idx      <= '0;
        end else if (load && state == SEQ_IDLE) begin
            resp_buf <= {byte2, byte1, byte0};
            len_q    <= len;
            idx      <= '0;
        end else if (state == SEQ_SEND) begin
            idx <= idx + 2'd1;
        end
    end

    always_comb begin
        room      = TX_USEDW < TX_LIMIT;
        last      = idx == (len_q - 2'd1);
        state_nxt = state;
        case (state)
            SEQ_IDLE: if (load) state_nxt = SEQ_WAIT;
            SEQ_WAIT: if (room) state_nxt = SEQ_SEND;
            SEQ_SEND: if (last) state_nxt = SEQ_IDLE;
            default:  state_nxt = SEQ_IDLE;
        endcase
    end

    always_comb begin
        start    = (state == SEQ_WAIT) && room;
        done     = (state == SEQ_SEND) && last;
        TX_WRREQ = state == SEQ_SEND;
        TX_DIN   = (state == SEQ_SEND) ? resp_buf[idx] : 8'h00;
    end

endmodule

// File: rtl/uart_reg_bridge.sv
// Parses 5-byte command frames from the UART receive FIFO, performs one
// register access per frame and queues the acknowledge/response frame.
module uart_reg_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned TIMEOUT_CLKS = 50000
) (
    input  logic                  CLK,
    input  logic                  RST,
    output logic                  RX_RDREQ,
    input  logic [7:0]            RX_DOUT,
    input  logic [ADDR_WIDTH-1:0] RX_USEDW,
    output logic                  TX_WRREQ,
    output logic [7:0]            TX_DIN,
    input  logic [ADDR_WIDTH-1:0] TX_USEDW,
    output logic [7:0]            REG_ADDR,
    output logic [7:0]            REG_WDATA,
    output logic                  REG_WE,
    output logic                  REG_RE,
    input  logic [7:0]            REG_RDATA,
    output logic [7:0]            ERR_CNT
);

    localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CLKS);

    bridge_state_t state;
    bridge_state_t state_nxt;
    frame_kind_t   kind;

    logic        rx_rdreq;
    logic        byte_valid;
    logic [2:0]  byte_idx;
    logic [7:0]  cmd_q;
    logic [7:0]  addr_q;
    logic [7:0]  data_q;
    logic [7:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  err_cnt;
    logic [31:0] tmo_cnt;

    logic        sync_hit;
    logic        collect_hit;
    logic        last_byte;
    logic        tmo_hit;
    logic        rd_issue;
    logic        err_inc;

    logic        seq_load;
    logic [1:0]  seq_len;
    logic [7:0]  seq_b0;
    logic [7:0]  seq_b1;
    logic [7:0]  seq_b2;
    logic        seq_start;
    logic        seq_done;

    // A byte arrives the cycle after its fetch; never fetch past the checksum byte.
    always_comb begin
        sync_hit    = byte_valid && (state == HUNT) && (RX_DOUT == SYNC_BYTE);
        collect_hit = byte_valid && (state == COLLECT);
        last_byte   = collect_hit && (byte_idx == 3'd4);
        tmo_hit     = (state == COLLECT) && !byte_valid && ((tmo_cnt + 32'd1) == TIMEOUT_LIMIT);
        rd_issue    = !rx_rdreq && (RX_USEDW != '0) &&
                      ((state == HUNT) || ((state == COLLECT) && !last_byte && !tmo_hit));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HUNT:      if (sync_hit) state_nxt = COLLECT;
            COLLECT: begin
                if (last_byte) begin
                    state_nxt = EXEC;
                end else if (tmo_hit) begin
                    state_nxt = HUNT;
                end
            end
            EXEC:      state_nxt = (kind == FRAME_RD) ? RD_WAIT : RESP_WAIT;
            RD_WAIT:   state_nxt = RESP_WAIT;
            RESP_WAIT: if (seq_start) state_nxt = RESP;
            RESP:      if (seq_done) state_nxt = HUNT;
            default:   state_nxt = HUNT;
        endcase
    end

    always_comb begin
        REG_WE   = (state == EXEC) && (kind == FRAME_WR);
        REG_RE   = (state == EXEC) && (kind == FRAME_RD);
        err_inc  = ((state == EXEC) && (kind == FRAME_BAD)) || tmo_hit;
        seq_load = 1'b0;
        seq_len  = 2'd1;
        seq_b0   = ACK_BYTE;
        seq_b1   = 8'h00;
        seq_b2   = 8'h00;
        if (state == EXEC && kind != FRAME_RD) begin
            seq_load = 1'b1;
            seq_b0   = (kind == FRAME_WR) ? ACK_BYTE : NAK_BYTE;
        end else if (state == RD_WAIT) begin
            seq_load = 1'b1;
            seq_len  = 2'd3;
            seq_b1   = REG_RDATA;
            seq_b2   = REG_RDATA ^ ACK_BYTE;
        end
    end

    // Register address/data only change when a valid frame is about to execute.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_rdreq   <= 1'b0;
            byte_valid <= 1'b0;
            byte_idx   <= '0;
            cmd_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            kind       <= FRAME_BAD;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            tmo_cnt    <= '0;
            err_cnt    <= '0;
        end else begin
            rx_rdreq   <= rd_issue;
            byte_valid <= rx_rdreq;

            if (sync_hit) begin
                byte_idx <= 3'd1;
            end else if (collect_hit) begin
                byte_idx <= byte_idx + 3'd1;
                case (byte_idx)
                    3'd1:    cmd_q  <= RX_DOUT;
                    3'd2:    addr_q <= RX_DOUT;
                    3'd3:    data_q <= RX_DOUT;
                    default: begin
                        kind <= classify_frame(cmd_q, addr_q, data_q, RX_DOUT);
                        if (classify_frame(cmd_q, addr_q, data_q, RX_DOUT) != FRAME_BAD) begin
                            reg_addr <= addr_q;
                        end
                        if (classify_frame(cmd_q, addr_q, data_q, RX_DOUT) == FRAME_WR) begin
                            reg_wdata <= data_q;
                        end
                    end
                endcase
            end

            if (state != COLLECT || collect_hit || tmo_hit) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end

            if (err_inc && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    uart_resp_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_resp_seq (
        .CLK      (CLK),
        .RST      (RST),
        .load     (seq_load),
        .len      (seq_len),
        .byte0    (seq_b0),
        .byte1    (seq_b1),
        .byte2    (seq_b2),
        .TX_USEDW (TX_USEDW),
        .start    (seq_start),
        .done     (seq_done),
        .TX_WRREQ (TX_WRREQ),
        .TX_DIN   (TX_DIN)
    );

    assign RX_RDREQ  = rx_rdreq;
    assign REG_ADDR  = reg_addr;
    assign REG_WDATA = reg_wdata;
    assign ERR_CNT   = err_cnt;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Bench for uart_reg_bridge: FIFO and register-bus models around the DUT,
// directed and random frames checked against a frame-level reference model.
module tb_uart_reg_bridge;

    localparam int TMO = 300;

    logic       CLK;
    logic       RST;
    logic       RX_RDREQ;
    logic [7:0] RX_DOUT;
    logic [7:0] RX_USEDW;
    logic       TX_WRREQ;
    logic [7:0] TX_DIN;
    logic [7:0] TX_USEDW;
    logic [7:0] REG_ADDR;
    logic [7:0] REG_WDATA;
    logic       REG_WE;
    logic       REG_RE;
    logic [7:0] REG_RDATA;
    logic [7:0] ERR_CNT;

    int total = 0;
    int bad   = 0;

    logic [7:0] rx_mem [0:8191];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         cyc = 0;

    logic [7:0] slv_regs [0:255];
    logic [7:0] we_addr[$];
    logic [7:0] we_data[$];
    logic [7:0] re_addr[$];
    logic [7:0] tx_data[$];
    int         tx_cyc[$];
    int         both_cnt = 0;
    int         room_viol = 0;
    int         underflow = 0;

    logic [7:0] exp_regs [0:255];
    int         exp_err = 0;

    uart_reg_bridge #(
        .ADDR_WIDTH   (8),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_RDREQ  (RX_RDREQ),
        .RX_DOUT   (RX_DOUT),
        .RX_USEDW  (RX_USEDW),
        .TX_WRREQ  (TX_WRREQ),
        .TX_DIN    (TX_DIN),
        .TX_USEDW  (TX_USEDW),
        .REG_ADDR  (REG_ADDR),
        .REG_WDATA (REG_WDATA),
        .REG_WE    (REG_WE),
        .REG_RE    (REG_RE),
        .REG_RDATA (REG_RDATA),
        .ERR_CNT   (ERR_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign RX_USEDW = 8'(wr_ptr - rd_ptr);

    // Receive FIFO, register slave and send FIFO models
    initial begin
        for (int i = 0; i < 256; i++) slv_regs[i] = 8'h00;
        RX_DOUT   = 8'h00;
        REG_RDATA = 8'h00;
    end

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (RX_RDREQ) begin
            if (rd_ptr != wr_ptr) begin
                RX_DOUT <= rx_mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1;
            end else begin
                underflow <= underflow + 1;
            end
        end
        if (REG_WE) begin
            we_addr.push_back(REG_ADDR);
            we_data.push_back(REG_WDATA);
            slv_regs[REG_ADDR] <= REG_WDATA;
        end
        if (REG_RE) begin
            re_addr.push_back(REG_ADDR);
            REG_RDATA <= slv_regs[REG_ADDR];
        end
        if (REG_WE && REG_RE) both_cnt <= both_cnt + 1;
        if (TX_WRREQ) begin
            tx_data.push_back(TX_DIN);
            tx_cyc.push_back(cyc);
            if (TX_USEDW >= 8'd252) room_viol <= room_viol + 1;
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic pushByte(input logic [7:0] b);
        rx_mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    function automatic logic [7:0] junkByte();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255)); while (b == 8'h55);
        return b;
    endfunction

    // One frame: push it (optionally with junk, gaps and send-FIFO stall), then check everything it should cause
    task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data,
                                 input logic [7:0] chk, input int junk_n, input int gap_max, input bit stall);
        int         we0, re0, tx0, exp_len, exp_we, exp_re, budget;
        logic [7:0] exp_resp [3];
        logic [7:0] frame [5];
        logic [7:0] rd;
        we0 = we_addr.size();
        re0 = re_addr.size();
        tx0 = tx_data.size();
        exp_we = 0;
        exp_re = 0;
        exp_resp[1] = 8'h00;
        exp_resp[2] = 8'h00;
        if ((cmd ^ addr ^ data) == chk && cmd == 8'h01) begin
            exp_we = 1;
            exp_regs[addr] = data;
            exp_len = 1;
            exp_resp[0] = 8'hAA;
        end else if ((cmd ^ addr ^ data) == chk && cmd == 8'h02) begin
            exp_re = 1;
            rd = exp_regs[addr];
            exp_len = 3;
            exp_resp[0] = 8'hAA;
            exp_resp[1] = rd;
            exp_resp[2] = rd ^ 8'hAA;
        end else begin
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
            exp_len = 1;
            exp_resp[0] = 8'hEE;
        end

        if (stall) TX_USEDW = 8'd252;
        frame[0] = 8'h55; frame[1] = cmd; frame[2] = addr; frame[3] = data; frame[4] = chk;
        for (int j = 0; j < junk_n; j++) pushByte(junkByte());
        for (int j = 0; j < 5; j++) begin
            pushByte(frame[j]);
            repeat ($urandom_range(0, gap_max)) @(negedge CLK);
        end
        if (stall) begin
            repeat (60) @(negedge CLK);
            checkOutput("stall_hold", 32'(tx_data.size() - tx0), 0);
            TX_USEDW = 8'd251;
        end

        budget = 500;
        while ((tx_data.size() < tx0 + exp_len) && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        checkOutput("resp_arrived", 32'(budget > 0), 1);
        repeat (5) @(negedge CLK);
        TX_USEDW = 8'd0;

        checkOutput("resp_len", 32'(tx_data.size() - tx0), 32'(exp_len));
        for (int j = 0; j < exp_len; j++) checkOutput("resp_byte", 32'(tx_data[tx0 + j]), 32'(exp_resp[j]));
        if (exp_len > 1) checkOutput("resp_burst", 32'(tx_cyc[tx0 + exp_len - 1] - tx_cyc[tx0]), 32'(exp_len - 1));
        checkOutput("we_count", 32'(we_addr.size() - we0), 32'(exp_we));
        if (exp_we == 1) begin
            checkOutput("we_addr", 32'(we_addr[we0]), 32'(addr));
            checkOutput("we_data", 32'(we_data[we0]), 32'(data));
        end
        checkOutput("re_count", 32'(re_addr.size() - re0), 32'(exp_re));
        if (exp_re == 1) checkOutput("re_addr", 32'(re_addr[re0]), 32'(addr));
        checkOutput("err_cnt", 32'(ERR_CNT), 32'(exp_err));
    endtask

    initial begin
        int         we0, re0, tx0;
        logic [7:0] c, a, d, k;
        for (int i = 0; i < 256; i++) exp_regs[i] = 8'h00;
        RST      = 1'b1;
        TX_USEDW = 8'd0;
        repeat (3) @(negedge CLK);
        checkOutput("reset_strobes", {28'd0, RX_RDREQ, TX_WRREQ, REG_WE, REG_RE}, 0);
        checkOutput("reset_busses", {REG_ADDR, REG_WDATA, TX_DIN, ERR_CNT}, 0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        $display("[TB] directed frames");
        applyStimulus(8'h01, 8'h10, 8'h3C, 8'h2D, 0, 0, 1'b0);
        applyStimulus(8'h01, 8'h20, 8'h5A, 8'h7B, 0, 0, 1'b0);
        applyStimulus(8'h02, 8'h20, 8'h00, 8'h22, 0, 0, 1'b0);
        applyStimulus(8'h01, 8'h10, 8'h3C, 8'h00, 0, 0, 1'b0);
        pushByte(8'h00);
        pushByte(8'hFF);
        applyStimulus(8'h01, 8'h01, 8'h01, 8'h01, 0, 0, 1'b0);
        applyStimulus(8'h02, 8'h20, 8'h00, 8'h22, 0, 0, 1'b1);

        $display("[TB] inter-byte timeout");
        we0 = we_addr.size();
        re0 = re_addr.size();
        tx0 = tx_data.size();
        pushByte(8'h55);
        pushByte(8'h01);
        repeat (TMO / 2) @(negedge CLK);
        checkOutput("tmo_early", 32'(ERR_CNT), 32'(exp_err));
        repeat (TMO) @(negedge CLK);
        exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        checkOutput("tmo_err", 32'(ERR_CNT), 32'(exp_err));
        checkOutput("tmo_strobes", 32'(we_addr.size() - we0 + re_addr.size() - re0), 0);
        checkOutput("tmo_resp", 32'(tx_data.size() - tx0), 0);
        applyStimulus(8'h01, 8'h33, 8'hC4, 8'hF6, 0, 0, 1'b0);

        $display("[TB] reset mid-frame");
        pushByte(8'h55);
        pushByte(8'h01);
        pushByte(8'h10);
        repeat (20) @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("rst_strobes", {28'd0, RX_RDREQ, TX_WRREQ, REG_WE, REG_RE}, 0);
        checkOutput("rst_busses", {REG_ADDR, REG_WDATA, TX_DIN, ERR_CNT}, 0);
        @(negedge CLK);
        RST = 1'b0;
        exp_err = 0;
        applyStimulus(8'h01, 8'h44, 8'h12, 8'h57, 0, 0, 1'b0);

        $display("[TB] random frames");
        for (int n = 0; n < 40; n++) begin
            a = 8'($urandom_range(0, 15));
            d = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0: begin c = 8'h01; k = c ^ a ^ d; end
                1: begin c = 8'h02; k = c ^ a ^ d; end
                2: begin c = 8'h01; k = (c ^ a ^ d) ^ 8'($urandom_range(1, 255)); end
                default: begin
                    do c = 8'($urandom_range(0, 255)); while (c == 8'h01 || c == 8'h02);
                    k = c ^ a ^ d;
                end
            endcase
            applyStimulus(c, a, d, k, $urandom_range(0, 3), $urandom_range(0, 4),
                          $urandom_range(0, 7) == 0);
        end

        $display("[TB] error counter saturation");
        tx0 = tx_data.size();
        for (int b = 0; b < 26; b++) begin
            for (int f = 0; f < 10; f++) begin
                pushByte(8'h55); pushByte(8'h01); pushByte(8'h10); pushByte(8'h3C); pushByte(8'h00);
                exp_err = (exp_err < 255) ? exp_err + 1 : 255;
            end
            repeat (400) @(negedge CLK);
        end
        checkOutput("sat_resp_count", 32'(tx_data.size() - tx0), 260);
        checkOutput("sat_last_resp", 32'(tx_data[tx_data.size() - 1]), 32'h0EE);
        checkOutput("sat_err", 32'(ERR_CNT), 32'(exp_err));

        checkOutput("we_re_overlap", 32'(both_cnt), 0);
        checkOutput("tx_room", 32'(room_viol), 0);
        checkOutput("rx_underflow", 32'(underflow), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
